seq_shifter: RTL and testbench

Multicycle barrel-shift replacement for the datapath's shift unit: the consumer of the shift-amount select mux. It accepts an operand, a 32-bit shift-amount word (of which only bits [4:0] are used) and an operation code on a `start` pulse. It then shifts one bit position per clock and reports completion with a one-cycle `done` pulse. The control FSM holds the pipeline in the execute step until `done` rises, then writes `result` back.

---
 rtl/seq_shifter.sv | 80 ++++++++
 tb/tb_seq_shifter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/seq_shifter.sv
// Multicycle shift unit: moves the operand one bit position per clock and
// pulses done for one cycle once the captured amount has been consumed.
module seq_shifter (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src,
  input  logic [31:0] amt_in,
  output logic [31:0] result,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state;
  logic [4:0]  count;
  logic [2:0]  opReg;

  // Only the low five bits of the amount word are meaningful.
  logic unusedAmtHi;
  assign unusedAmtHi = ^amt_in[31:5];

  function automatic logic [31:0] stepOnce(input logic [2:0] o, input logic [31:0] v);
    case (o)
      3'b000:  stepOnce = {v[30:0], 1'b0};
      3'b001:  stepOnce = {1'b0, v[31:1]};
      3'b010:  stepOnce = {v[31], v[31:1]};
      3'b011:  stepOnce = {v[30:0], v[31]};
      3'b100:  stepOnce = {v[0], v[31:1]};
      default: stepOnce = v;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      count  <= '0;
      opReg  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            result <= src;
            count  <= amt_in[4:0];
            opReg  <= op;
            state  <= SHIFT;
            busy   <= 1'b1;
            done   <= 1'b0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end
        SHIFT: begin
          if (count != 5'd0) begin
            result <= stepOnce(opReg, result);
            count  <= count - 5'd1;
          end else begin
            // Last SHIFT cycle leaves result untouched and hands off to DONE.
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shifter.sv
// Self-checking bench for seq_shifter: directed cases, back-to-back, mid-run
// reset and randomized operations against an arithmetic reference model.
module tb_seq_shifter;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src;
  logic [31:0] amt_in;
  logic [31:0] result;
  logic        busy;
  logic        done;

  int nCmp = 0;
  int nErr = 0;

  seq_shifter dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .src(src),
    .amt_in(amt_in), .result(result), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] refModel(input logic [2:0] o, input logic [31:0] s, input int n);
    case (o)
      3'd0: return s << n;
      3'd1: return s >> n;
      3'd2: return 32'($signed(s) >>> n);
      3'd3: return (n == 0) ? s : ((s << n) | (s >> (32 - n)));
      3'd4: return (n == 0) ? s : ((s >> n) | (s << (32 - n)));
      default: return s;
    endcase
  endfunction

  task automatic launch(input logic [2:0] o, input logic [31:0] s, input logic [31:0] a);
    @(negedge clk);
    start = 1'b1; op = o; src = s; amt_in = a;
  endtask

  // Walks cycles 1..N+2 after the sampling edge; returns in the DONE cycle.
  task automatic follow(input string name, input logic [31:0] exp, input int n, input bit holdStart);
    @(posedge clk);
    for (int k = 1; k <= n + 2; k++) begin
      @(negedge clk);
      if (!holdStart) start = 1'b0;
      src = $urandom; op = 3'($urandom_range(0, 7)); amt_in = $urandom;
      nCmp++;
      if (busy !== (k <= n + 1)) begin
        nErr++; $display("FAIL %s busy cycle %0d: got %b want %b", name, k, busy, (k <= n + 1));
      end
      nCmp++;
      if (done !== (k == n + 2)) begin
        nErr++; $display("FAIL %s done cycle %0d: got %b want %b", name, k, done, (k == n + 2));
      end
    end
    nCmp++;
    if (result !== exp) begin
      nErr++; $display("FAIL %s result: got %h want %h", name, result, exp);
    end
  endtask

  task automatic finishIdle(input string name, input logic [31:0] exp);
    start = 1'b0;
    @(negedge clk);
    nCmp++;
    if (done !== 1'b0 || busy !== 1'b0 || result !== exp) begin
      nErr++; $display("FAIL %s idle: got done=%b busy=%b result=%h want 0 0 %h", name, done, busy, result, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; op = '0; src = '0; amt_in = '0;
    repeat (2) @(negedge clk);
    nCmp++;
    if (result !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
      nErr++; $display("FAIL reset: got result=%h busy=%b done=%b want 0 0 0", result, busy, done);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    nCmp++;
    if (result !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
      nErr++; $display("FAIL idle_after_reset: got result=%h busy=%b done=%b want 0 0 0", result, busy, done);
    end
  endtask

  task automatic test_directed();
    launch(3'b010, 32'h80000000, 32'h4);          follow("sra4", 32'hF8000000, 4, 0);  finishIdle("sra4", 32'hF8000000);
    launch(3'b000, 32'h00000001, 32'h1F);         follow("sll31", 32'h80000000, 31, 0); finishIdle("sll31", 32'h80000000);
    launch(3'b001, 32'h80000000, 32'h1F);         follow("srl31", 32'h00000001, 31, 0); finishIdle("srl31", 32'h00000001);
    launch(3'b100, 32'h00000001, 32'hFFFFFFE1);   follow("ror1", 32'h80000000, 1, 0);  finishIdle("ror1", 32'h80000000);
    launch(3'b011, 32'h80000000, 32'h1);          follow("rol1", 32'h00000001, 1, 0);  finishIdle("rol1", 32'h00000001);
    launch(3'b001, 32'h12345678, 32'h20);         follow("srl0", 32'h12345678, 0, 0);  finishIdle("srl0", 32'h12345678);
    launch(3'b110, 32'hCAFEBABE, 32'h5);          follow("pass5", 32'hCAFEBABE, 5, 0); finishIdle("pass5", 32'hCAFEBABE);
  endtask

  task automatic test_back_to_back();
    launch(3'b000, 32'h1, 32'h2);
    follow("b2b_first", 32'h4, 2, 1);
    // Still in the DONE cycle with start high: second request accepted here.
    start = 1'b1; op = 3'b001; src = 32'h100; amt_in = 32'h8;
    follow("b2b_second", 32'h1, 8, 0);
    finishIdle("b2b_second", 32'h1);
  endtask

  task automatic test_mid_reset();
    launch(3'b000, $urandom, 32'hA);
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    nCmp++;
    if (result !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
      nErr++; $display("FAIL mid_reset: got result=%h busy=%b done=%b want 0 0 0", result, busy, done);
    end
    @(negedge clk); reset = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      nCmp++;
      if (result !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
        nErr++; $display("FAIL post_reset cycle %0d: got result=%h busy=%b done=%b want 0 0 0", k, result, busy, done);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      logic [31:0] s, a, e;
      logic [2:0]  o;
      s = $urandom; a = $urandom; o = 3'($urandom_range(0, 7));
      e = refModel(o, s, int'(a[4:0]));
      launch(o, s, a);
      follow($sformatf("rand%0d_op%0d", i, o), e, int'(a[4:0]), 0);
      finishIdle("rand", e);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
